// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - sample history memory controller (circular write, tap read, clear)
//
// Purpose: writes each incoming sample into a 256-entry circular buffer, serves
// tap reads of x(n-k), zero-fills the memory on request and, when built with
// ZERO_SLEEP_DETECT_EN, flags a run of ZERO_LIMIT consecutive zero samples.
//
// Ports:
//   Sclk, Reset                      clock, asynchronous active-high reset
//   input_rdy_flag, data_in          sample strobe (rising edge = new sample), sample
//   clear_req                        zero-fill the whole memory
//   rd_req, rd_k                     tap read request (held until rd_valid), tap delay
//   wr_en, data_wr_addr, mem_wr_data memory write port
//   rd_en, data_rd_addr              memory read port
//   rd_valid, rd_zero                read issued pulse; tap predates first sample
//   new_sample, busy                 sample write pulse; WRITE or CLEAR in progress
//   overrun, sleep_flag              sticky lost-sample flag; zero-run detected
module data_mem_ctrl #(
  parameter int DW         = 16,
  parameter int AW         = 8,
  parameter int ZERO_LIMIT = 800
) (
  input  logic          Sclk,
  input  logic          Reset,
  input  logic          input_rdy_flag,
  input  logic [DW-1:0] data_in,
  input  logic          clear_req,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_k,
  output logic          wr_en,
  output logic [AW-1:0] data_wr_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic          rd_en,
  output logic [AW-1:0] data_rd_addr,
  output logic          rd_valid,
  output logic          rd_zero,
  output logic          new_sample,
  output logic          busy,
  output logic          overrun,
  output logic          sleep_flag
);

  typedef enum logic [1:0] {ST_READY, ST_WRITE, ST_CLEAR} state_t;

  localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

  state_t        state_q, state_d;
  logic          flag_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] pend_data_q, pend_data_d;
  logic          overrun_q, overrun_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] data_wr_addr_q, data_wr_addr_d;
  logic [DW-1:0] mem_wr_data_q, mem_wr_data_d;
  logic          rd_en_q, rd_en_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_zero_q, rd_zero_d;
  logic [AW-1:0] data_rd_addr_q, data_rd_addr_d;
  logic          new_sample_q, new_sample_d;

  logic          smp_edge;
  logic          do_write;
  logic [DW-1:0] wdata;
  logic          consume;
  logic          edge_taken;

  assign smp_edge = input_rdy_flag & ~flag_q;

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    cnt_d          = cnt_q;
    clr_cnt_d      = clr_cnt_q;
    pend_d         = pend_q;
    pend_data_d    = pend_data_q;
    overrun_d      = overrun_q;
    wr_en_d        = 1'b0;
    data_wr_addr_d = data_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    rd_en_d        = 1'b0;
    rd_valid_d     = 1'b0;
    rd_zero_d      = 1'b0;
    data_rd_addr_d = data_rd_addr_q;
    new_sample_d   = 1'b0;
    do_write       = 1'b0;
    wdata          = '0;
    consume        = 1'b0;
    edge_taken     = 1'b0;

    unique case (state_q)
      ST_READY: begin
        if (smp_edge) begin
          do_write = 1'b1;
          wdata    = data_in;
          state_d  = ST_WRITE;
        end else if (rd_req && !rd_valid_q) begin
          // rd_valid_q guard stops a still-held request being taken twice.
          rd_en_d        = 1'b1;
          rd_valid_d     = 1'b1;
          data_rd_addr_d = wr_ptr_q - AW'(1) - rd_k;
          rd_zero_d      = ({1'b0, rd_k} >= cnt_q);
        end else if (clear_req) begin
          state_d        = ST_CLEAR;
          clr_cnt_d      = '0;
          wr_en_d        = 1'b1;
          data_wr_addr_d = '0;
          mem_wr_data_d  = '0;
        end
      end
      ST_WRITE, ST_CLEAR: begin
        if (state_q == ST_CLEAR && clr_cnt_q != '1) begin
          clr_cnt_d      = clr_cnt_q + AW'(1);
          wr_en_d        = 1'b1;
          data_wr_addr_d = clr_cnt_q + AW'(1);
          mem_wr_data_d  = '0;
        end else begin
          if (state_q == ST_CLEAR) begin
            wr_ptr_d = '0;
            cnt_d    = '0;
          end
          // Leaving a busy state: a pending or same-cycle edge goes straight
          // into another WRITE so READY never holds a full pending slot.
          if (pend_q) begin
            do_write = 1'b1;
            wdata    = pend_data_q;
            consume  = 1'b1;
            state_d  = ST_WRITE;
          end else if (smp_edge) begin
            do_write   = 1'b1;
            wdata      = data_in;
            edge_taken = 1'b1;
            state_d    = ST_WRITE;
          end else begin
            state_d = ST_READY;
          end
        end
      end
      default: state_d = ST_READY;
    endcase

    if (do_write) begin
      wr_en_d        = 1'b1;
      new_sample_d   = 1'b1;
      data_wr_addr_d = wr_ptr_d;
      mem_wr_data_d  = wdata;
      wr_ptr_d       = wr_ptr_d + AW'(1);
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + (AW+1)'(1);
    end

    if (consume) pend_d = 1'b0;

    if (state_q != ST_READY && smp_edge && !edge_taken) begin
      if (pend_q && !consume) begin
        overrun_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_data_d = data_in;
      end
    end
  end

  always_ff @(posedge Sclk or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_READY;
      flag_q         <= 1'b0;
      wr_ptr_q       <= '0;
      cnt_q          <= '0;
      clr_cnt_q      <= '0;
      pend_q         <= 1'b0;
      pend_data_q    <= '0;
      overrun_q      <= 1'b0;
      wr_en_q        <= 1'b0;
      data_wr_addr_q <= '0;
      mem_wr_data_q  <= '0;
      rd_en_q        <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_zero_q      <= 1'b0;
      data_rd_addr_q <= '0;
      new_sample_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      flag_q         <= input_rdy_flag;
      wr_ptr_q       <= wr_ptr_d;
      cnt_q          <= cnt_d;
      clr_cnt_q      <= clr_cnt_d;
      pend_q         <= pend_d;
      pend_data_q    <= pend_data_d;
      overrun_q      <= overrun_d;
      wr_en_q        <= wr_en_d;
      data_wr_addr_q <= data_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      rd_en_q        <= rd_en_d;
      rd_valid_q     <= rd_valid_d;
      rd_zero_q      <= rd_zero_d;
      data_rd_addr_q <= data_rd_addr_d;
      new_sample_q   <= new_sample_d;
    end
  end

`ifdef ZERO_SLEEP_DETECT_EN
  localparam int ZW = $clog2(ZERO_LIMIT + 1);

  logic [ZW-1:0] zero_cnt_q, zero_cnt_d;
  logic          sleep_q, sleep_d;

  // Only sample writes count; CLEAR fill writes never assert do_write.
  always_comb begin
    zero_cnt_d = zero_cnt_q;
    sleep_d    = sleep_q;
    if (do_write) begin
      if (wdata == '0) begin
        if (zero_cnt_q != ZW'(ZERO_LIMIT)) zero_cnt_d = zero_cnt_q + ZW'(1);
        sleep_d = (zero_cnt_d == ZW'(ZERO_LIMIT));
      end else begin
        zero_cnt_d = '0;
        sleep_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge Sclk or posedge Reset) begin
    if (Reset) begin
      zero_cnt_q <= '0;
      sleep_q    <= 1'b0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
      sleep_q    <= sleep_d;
    end
  end

  assign sleep_flag = sleep_q;
`else
  // Detection not built: ZERO_LIMIT is irrelevant and this compare is constant 0.
  assign sleep_flag = (ZERO_LIMIT < 0);
`endif

  assign wr_en        = wr_en_q;
  assign data_wr_addr = data_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign rd_en        = rd_en_q;
  assign data_rd_addr = data_rd_addr_q;
  assign rd_valid     = rd_valid_q;
  assign rd_zero      = rd_zero_q;
  assign new_sample   = new_sample_q;
  assign busy         = (state_q != ST_READY);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
//
// Purpose: directed stimulus with write/read scoreboards; sleep checks follow
// ZERO_SLEEP_DETECT_EN. Ports: none (top-level bench).
module tb_data_mem_ctrl;

  logic        Sclk = 1'b0;
  logic        Reset;
  logic        input_rdy_flag;
  logic [15:0] data_in;
  logic        clear_req;
  logic        rd_req;
  logic [7:0]  rd_k;
  logic        wr_en;
  logic [7:0]  data_wr_addr;
  logic [15:0] mem_wr_data;
  logic        rd_en;
  logic [7:0]  data_rd_addr;
  logic        rd_valid;
  logic        rd_zero;
  logic        new_sample;
  logic        busy;
  logic        overrun;
  logic        sleep_flag;

  data_mem_ctrl #(.DW(16), .AW(8), .ZERO_LIMIT(800)) dut (
    .Sclk(Sclk), .Reset(Reset), .input_rdy_flag(input_rdy_flag), .data_in(data_in),
    .clear_req(clear_req), .rd_req(rd_req), .rd_k(rd_k), .wr_en(wr_en),
    .data_wr_addr(data_wr_addr), .mem_wr_data(mem_wr_data), .rd_en(rd_en),
    .data_rd_addr(data_rd_addr), .rd_valid(rd_valid), .rd_zero(rd_zero),
    .new_sample(new_sample), .busy(busy), .overrun(overrun), .sleep_flag(sleep_flag)
  );

  always #5 Sclk = ~Sclk;

`ifdef ZERO_SLEEP_DETECT_EN
  localparam logic SLEEP_EXP = 1'b1;
`else
  localparam logic SLEEP_EXP = 1'b0;
`endif

  typedef struct packed { logic [7:0] a; logic [15:0] d; logic ns; } wr_t;
  typedef struct packed { logic [7:0] a; logic z; } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  int  checks = 0;
  int  passed = 0;
  int  m_wr_ptr = 0;
  int  m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [39:0] all_outs();
    return {wr_en, data_wr_addr, mem_wr_data, rd_en, data_rd_addr, rd_valid,
            rd_zero, new_sample, busy, overrun, sleep_flag};
  endfunction

  always @(negedge Sclk) begin
    if (wr_en === 1'b1) begin
      check("wr_expected", wq.size() != 0, 1);
      if (wq.size() != 0) begin
        wr_t e;
        e = wq.pop_front();
        check("wr_port", {data_wr_addr, mem_wr_data, new_sample}, e);
      end
    end
    if (rd_valid === 1'b1) begin
      check("rd_expected", rq.size() != 0, 1);
      if (rq.size() != 0) begin
        rd_t r;
        r = rq.pop_front();
        check("rd_port", {rd_en, data_rd_addr, rd_zero}, {1'b1, r.a, r.z});
      end
    end
  end

  task automatic push_write(input logic [15:0] d);
    wr_t e;
    e.a = 8'(m_wr_ptr); e.d = d; e.ns = 1'b1;
    wq.push_back(e);
    m_wr_ptr = (m_wr_ptr + 1) % 256;
    if (m_cnt < 256) m_cnt++;
  endtask

  task automatic push_clear();
    wr_t e;
    for (int i = 0; i < 256; i++) begin
      e.a = 8'(i); e.d = 16'h0; e.ns = 1'b0;
      wq.push_back(e);
    end
  endtask

  task automatic push_read(input int k);
    rd_t r;
    r.a = 8'((m_wr_ptr - 1 - k) & 255);
    r.z = (k >= m_cnt);
    rq.push_back(r);
  endtask

  task automatic pulse(input logic [15:0] d);
    @(negedge Sclk); input_rdy_flag = 1'b1; data_in = d;
    @(negedge Sclk); input_rdy_flag = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] d, output logic slp);
    push_write(d);
    @(negedge Sclk); input_rdy_flag = 1'b1; data_in = d;
    @(negedge Sclk); slp = sleep_flag; input_rdy_flag = 1'b0;
  endtask

  task automatic do_read(input int k);
    logic got;
    got = 1'b0;
    push_read(k);
    @(negedge Sclk); rd_req = 1'b1; rd_k = 8'(k);
    for (int i = 0; i < 10; i++) begin
      @(negedge Sclk);
      if (rd_valid) begin got = 1'b1; break; end
    end
    rd_req = 1'b0;
    check("rd_done", got, 1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Sclk);
    check("reset_outputs", all_outs(), 0);
    Reset = 1'b0;
    m_wr_ptr = 0;
    m_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic s;
    logic last;
    int   ones;
    int   wc;
    int   rc;
    logic done;

    Reset = 1'b1; input_rdy_flag = 1'b0; data_in = '0;
    clear_req = 1'b0; rd_req = 1'b0; rd_k = '0;

    // Reset state, then samples 1..3 and tap reads.
    do_reset();
    send_sample(16'h0001, s);
    send_sample(16'h0002, s);
    send_sample(16'h0003, s);
    do_read(0);
    do_read(2);
    do_read(3);

    // Read request coincident with a sample edge: write goes first.
    push_write(16'h0044);
    push_read(0);
    @(negedge Sclk); input_rdy_flag = 1'b1; data_in = 16'h0044; rd_req = 1'b1; rd_k = 8'd0;
    wc = -1; rc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Sclk);
      input_rdy_flag = 1'b0;
      if (wr_en && wc < 0) wc = i;
      if (rd_valid) begin rc = i; break; end
    end
    rd_req = 1'b0;
    check("edge_before_read_gap", rc - wc, 2);

    // Wrap: 300 samples leave the pointer at 44.
    do_reset();
    for (int i = 0; i < 300; i++) send_sample(16'(i + 1), s);
    do_read(50);
    do_read(255);
    do_read(0);

    // Clear with two edges arriving during it.
    push_clear();
    m_wr_ptr = 0; m_cnt = 0;
    push_write(16'hAAAA);
    @(negedge Sclk); clear_req = 1'b1;
    @(negedge Sclk); clear_req = 1'b0;
    check("clear_busy", busy, 1);
    repeat (10) @(negedge Sclk);
    pulse(16'hAAAA);
    check("overrun_after_first", overrun, 0);
    repeat (10) @(negedge Sclk);
    pulse(16'hBBBB);
    check("overrun_after_second", overrun, 1);
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Sclk);
      if (!busy) begin done = 1'b1; break; end
    end
    check("clear_done", done, 1);
    do_read(0);
    do_read(1);

    // Zero-run detection.
    ones = 0; last = 1'b0;
    for (int i = 0; i < 800; i++) begin
      send_sample(16'h0000, s);
      if (i < 799) ones += int'(s);
      else last = s;
    end
    check("sleep_early", ones, 0);
    check("sleep_800th", last, SLEEP_EXP);
    send_sample(16'h0005, s);
    check("sleep_nonzero", s, 0);

    // Reset in the middle of a clear.
    push_clear();
    @(negedge Sclk); clear_req = 1'b1;
    @(negedge Sclk); clear_req = 1'b0;
    repeat (100) @(negedge Sclk);
    #2 Reset = 1'b1;
    #1 check("async_reset_outputs", all_outs(), 0);
    wq.delete();
    @(negedge Sclk);
    check("reset_wr_en", wr_en, 0);
    @(negedge Sclk);
    Reset = 1'b0;
    m_wr_ptr = 0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Sclk);
      check("post_reset_idle", {wr_en, busy}, 0);
    end
    send_sample(16'h1234, s);

    repeat (3) @(negedge Sclk);
    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: DW, 16, sample width.
REQ-002 Parameter: AW, 8, address width; depth = 2^AW = 256.
REQ-003 Parameter: ZERO_LIMIT, 800, consecutive zero samples before sleep.
REQ-004 Sclk  in  1  system clock; all state updates on posedge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 input_rdy_flag  in  1  sample strobe, level; rising edge marks a new sample.
REQ-007 data_in  in  DW  incoming sample, valid while input_rdy_flag high.
REQ-008 clear_req  in  1  request to zero-fill the whole data memory.
REQ-009 rd_req  in  1  tap read request; held until rd_valid.
REQ-010 rd_k  in  AW  tap delay k; target sample x(n-k).
REQ-011 wr_en / data_wr_addr / mem_wr_data  out  1/AW/DW  memory write port.
REQ-012 rd_en / data_rd_addr  out  1/AW  memory read port.
REQ-013 rd_valid  out  1  one-cycle pulse: read issued this cycle.
REQ-014 rd_zero  out  1  with rd_valid: x(n-k) predates first sample, consumer substitutes 0.
REQ-015 new_sample  out  1  one-cycle pulse on each sample write.
REQ-016 busy  out  1  high in WRITE or CLEAR.
REQ-017 overrun  out  1  sticky: sample edge lost.
REQ-018 sleep_flag  out  1  ZERO_LIMIT consecutive zero samples seen.

Function
REQ-019 FSM states READY, WRITE, CLEAR; Reset enters READY.
REQ-020 Rising-edge detect via registered copy of input_rdy_flag; data_in captured in edge cycle t.
REQ-021 Edge in READY: WRITE at t+1 -- wr_en=1, data_wr_addr=wr_ptr, mem_wr_data=captured sample, new_sample=1; wr_ptr+1 mod 256; back to READY at t+2.
REQ-022 sample_cnt (9 bits) increments per write, saturates at 256.
REQ-023 rd_req accepted only in READY with no edge in same cycle; edge wins, request held.
REQ-024 Accepted rd_req at t: at t+1 rd_en=1, rd_valid=1, data_rd_addr=(wr_ptr-1-rd_k) mod 256.
REQ-025 rd_zero=1 iff rd_k >= sample_cnt; rd_en still asserted.
REQ-026 rd_en=0, data_rd_addr held, outside read cycles; wr_en=0 outside WRITE/CLEAR.
REQ-027 clear_req in READY (no edge same cycle): CLEAR for 256 cycles, wr_en=1, mem_wr_data=0, addresses 0..255 ascending; then wr_ptr=0, sample_cnt=0, READY.
REQ-028 Edge during WRITE or CLEAR: latched to one-deep pending slot, serviced as WRITE immediately on return to READY.
REQ-029 Edge while pending slot full: sample dropped, overrun=1 until Reset.
REQ-030 clear_req during CLEAR or WRITE ignored; requester re-issues.

Reset
REQ-031 Reset asynchronously forces: READY, wr_ptr=0, sample_cnt=0, zero count=0, pending empty.
REQ-032 All outputs 0 in reset, including data_wr_addr, data_rd_addr, mem_wr_data.
REQ-033 Reset mid-CLEAR or mid-WRITE aborts; no further writes issued.

Configuration
REQ-034 Macro ZERO_SLEEP_DETECT_EN compiles in zero-sample detection.
REQ-035 With macro: each written sample of 0 increments a zero counter saturating at ZERO_LIMIT; sleep_flag=1 from the write cycle where count reaches ZERO_LIMIT; a nonzero write clears count and sleep_flag in that cycle; CLEAR does not change count.
REQ-036 Without macro: no zero counter, sleep_flag tied 0.

Verification
REQ-037 Write samples 1..3 -> addresses 0,1,2, one wr_en cycle each; rd_k=0 then 2 -> addr 2 then 0, rd_zero=0; rd_k=3 -> rd_zero=1.
REQ-038 300 samples -> wr_ptr wraps to 44; rd_k=50 -> addr 249; sample_cnt=256, rd_zero=0 for any k.
REQ-039 rd_req and edge in same cycle -> WRITE first, rd_valid two cycles later with addr using updated wr_ptr.
REQ-040 clear_req, then two edges during CLEAR -> 256 zero writes, first sample written to addr 0 immediately after, second dropped, overrun=1.
REQ-041 Macro on: 800 zero samples -> sleep_flag rises on 800th write; sample 0x0005 -> sleep_flag=0 that cycle; macro off -> sleep_flag stays 0.
REQ-042 Reset asserted at CLEAR cycle 100 -> outputs 0 immediately, wr_en low, READY after release.
